seg_uart_display: RTL and testbench
===================================

# seg_uart_display

Parametrised successor to the fixed 3-digit UART-to-7-segment path. It accepts received UART bytes as a valid-strobed stream and parses ASCII hex into an editable buffer of NUM_DIGITS nibbles. A commit command copies the buffer to the shown value, and the block drives a time-multiplexed, polarity-configurable 7-segment display with decimal points and optional leading-zero blanking. It sits between uart_rx_path and the display pins, and returns one-byte acknowledgements to uart_tx_path over a valid/ready handshake.

## Interface
- NUM_DIGITS, 3: number of display digits, 1..8.
- SCAN_DIV, 50000: clk cycles each digit is driven, ≥2.
- SEG_ACTIVE_LOW, 1: 1 = segment lines are active-low.
- DIG_ACTIVE_LOW, 1: 1 = digit selects are active-low.
- clk  in  1  single clock for all logic.
- reset_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  response pending.
- tx_ready  in  1  downstream accepts when tx_valid && tx_ready.
- seg_data  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- scan_sig  out  NUM_DIGITS  one-hot digit select; bit 0 = rightmost digit.
- disp_value  out  4*NUM_DIGITS  committed nibbles; nibble 0 = rightmost digit.
- commit_pulse  out  1  one-cycle strobe when disp_value updates.

## Operation
- Two-stage byte path: stage 1 registers rx_data on rx_valid; stage 2 decodes and applies the byte.
- Byte actions:
  - '0'-'9', 'a'-'f', 'A'-'F': edit buffer shifts left one nibble. The new nibble enters at digit 0 and the MSB nibble is discarded. The edit dp vector shifts the same way and dp[0] is cleared.
  - '.' (0x2E): sets edit dp[0].
  - '#' (0x23): clears the edit buffer and edit dp.
  - 'z' (0x7A): toggles blank_mode immediately; the change takes effect without a commit.
  - CR (0x0D): copies the edit buffer and edit dp to the display registers, pulses commit_pulse, and queues response 'K' (0x4B).
  - LF (0x0A): ignored, no response.
  - Any other byte: state unchanged; queues response '?' (0x3F).
- Response slot holds a single entry:
  - A queued response sets tx_valid and tx_data.
  - The slot clears on the cycle where tx_valid && tx_ready.
  - If a new response arrives while the slot is full and not being accepted in that cycle, the new response is discarded and the pending byte is kept.
  - If the slot is being accepted in the same cycle, the new response is loaded.
- Scan:
  - The counter counts 0..SCAN_DIV-1. At the wrap, the digit index advances 0..NUM_DIGITS-1 and then wraps to 0.
  - seg_data and scan_sig are registered from the current index.
- Decode, before polarity: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71. Bit 7 = dp of that digit.
- Leading-zero blanking:
  - When blank_mode = 1, digit i (i>0) is blanked if all committed nibbles i..NUM_DIGITS-1 are zero.
  - A blanked digit drives all segments off except its dp.
  - Digit 0 is never blanked.
- Polarity: the final segment vector is inverted when SEG_ACTIVE_LOW = 1, and the one-hot select is inverted when DIG_ACTIVE_LOW = 1.

## Timing
- rx_valid at cycle N → edit buffer, display registers, and blank_mode are updated at N+2.
- commit_pulse is high during N+2 only, and tx_valid rises at N+2.
- Back-to-back rx_valid on consecutive cycles is fully supported, with no stall and no byte lost.
- Display registers change only at a commit. The scan output reflects a new value from the cycle after the registers update.
- Digit dwell is exactly SCAN_DIV cycles. Full refresh period is NUM_DIGITS*SCAN_DIV cycles.
- Reset (any cycle, including mid-byte or with a response pending):
  - Clears both stages, the edit buffer, edit dp, display registers, display dp, blank_mode, scan counter, digit index, and the response slot.
  - Outputs during reset: tx_valid=0, tx_data=0x00, commit_pulse=0, disp_value=0.
  - seg_data is all segments off (0xFF when active-low); scan_sig is all digits inactive.
  - First cycle after release: digit 0 is selected and shows '0'.

## Structure
- Package seg_pkg holds:
  - the 16-entry SEG_LUT constant;
  - command byte constants: CMD_COMMIT, CMD_CLEAR, CMD_DP, CMD_BLANK, CMD_LF;
  - response constants: RSP_OK, RSP_ERR.
- Sub-module seg_scan (scan counter, index, blanking, decode, polarity) is instantiated once. Parser and response slot stay in the top module.

## Test plan
- NUM_DIGITS=3: send "12A\r" → disp_value=0x12A, one commit_pulse, tx_data=0x4B accepted. Scanned digits 0,1,2 show seg_data 0x88, 0xA4, 0xF9 (active-low).
- Send "1234\r" with NUM_DIGITS=3 → disp_value=0x234 (MSB nibble dropped).
- Send "5.\r", then 'z' → disp_value=0x005 with dp[0]=1 and digit 0 showing 0x12. After 'z', digits 1 and 2 show 0xFF; before 'z' they showed 0xC0.
- Send 'x' with tx_ready=0, then '#' and 'q' → tx_data stays 0x3F (second '?' dropped). Raise tx_ready → exactly one handshake.
- Send '7' then '\r' on consecutive cycles → disp_value=0x007 at cycle N+3 relative to the first rx_valid.
- Assert reset_n=0 during the decode stage of '\r' with a response pending → after release, disp_value=0, tx_valid=0, and scan restarts at digit 0 with SCAN_DIV dwell.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and byte classification for the UART-to-7-segment display path.
package seg_pkg;

    localparam logic [7:0] CMD_COMMIT = 8'h0D;
    localparam logic [7:0] CMD_CLEAR  = 8'h23;
    localparam logic [7:0] CMD_DP     = 8'h2E;
    localparam logic [7:0] CMD_BLANK  = 8'h7A;
    localparam logic [7:0] CMD_LF     = 8'h0A;

    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for hex digits 0..F
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [2:0] {
        BC_HEX,
        BC_DP,
        BC_CLEAR,
        BC_BLANK,
        BC_COMMIT,
        BC_IGNORE,
        BC_ERR
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e cls;
        if ((b >= 8'h30 && b <= 8'h39) ||
            (b >= 8'h41 && b <= 8'h46) ||
            (b >= 8'h61 && b <= 8'h66)) begin
            cls = BC_HEX;
        end else begin
            case (b)
                CMD_DP:     cls = BC_DP;
                CMD_CLEAR:  cls = BC_CLEAR;
                CMD_BLANK:  cls = BC_BLANK;
                CMD_COMMIT: cls = BC_COMMIT;
                CMD_LF:     cls = BC_IGNORE;
                default:    cls = BC_ERR;
            endcase
        end
        return cls;
    endfunction

    // Letters share low bits: 'A'/'a' = x1, so add 9 to land on 10.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/seg_uart_display_if.sv
// Byte stream from the UART receiver and acknowledgement path to the UART transmitter.
interface seg_uart_display_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed digit scan: dwell counter, digit index, leading-zero blanking,
// hex-to-segment decode and output polarity.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] disp_value,
    input  logic [NUM_DIGITS-1:0]   disp_dp,
    input  logic                    blank_mode,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   scan_sig
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    // XOR masks double as the "all off" pattern for each polarity
    localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            nib;
    logic                  upper_nonzero;
    logic                  blanked;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] sel;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
    always_comb begin
        nib           = disp_value[4*int'(idx) +: 4];
        upper_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && disp_value[4*i +: 4] != 4'h0) upper_nonzero = 1'b1;
        end
        blanked = blank_mode && (idx != '0) && !upper_nonzero;
        seg_raw = {disp_dp[idx], blanked ? 7'h00 : SEG_LUT[nib]};
        sel     = NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_data <= SEG_OFF;
            scan_sig <= DIG_OFF;
        end else begin
            seg_data <= seg_raw ^ SEG_OFF;
            scan_sig <= sel ^ DIG_OFF;
        end
    end

endmodule

// File: rtl/seg_uart_display.sv
// ASCII hex command parser with an editable digit buffer, commit to the displayed
// value, single-entry acknowledgement slot and a scanned 7-segment driver.
module seg_uart_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seg_uart_display_if.slave       uart,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   scan_sig,
    output logic [4*NUM_DIGITS-1:0] disp_value,
    output logic                    commit_pulse
);

    localparam int W = 4 * NUM_DIGITS;

    logic                  s1_valid;
    logic [7:0]            s1_data;
    byte_class_e           s1_class;
    logic [3:0]            s1_nibble;
    logic [W-1:0]          edit_buf;
    logic [NUM_DIGITS-1:0] edit_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  blank_mode;
    logic                  rsp_push;
    logic [7:0]            rsp_byte;
    logic                  tx_valid;
    logic [7:0]            tx_data;

    // Stage 1: capture the received byte
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= uart.rx_valid;
            if (uart.rx_valid) s1_data <= uart.rx_data;
        end
    end

    always_comb begin
        s1_class  = classify(s1_data);
        s1_nibble = hex_nibble(s1_data);
        rsp_push  = 1'b0;
        rsp_byte  = RSP_OK;
        if (s1_valid) begin
            if (s1_class == BC_COMMIT) begin
                rsp_push = 1'b1;
            end else if (s1_class == BC_ERR) begin
                rsp_push = 1'b1;
                rsp_byte = RSP_ERR;
            end
        end
    end

    // Stage 2: apply the decoded byte
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edit_buf     <= '0;
            edit_dp      <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            blank_mode   <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            if (s1_valid) begin
                case (s1_class)
                    BC_HEX: begin
                        edit_buf <= (edit_buf << 4) | W'(s1_nibble);
                        edit_dp  <= edit_dp << 1;
                    end
                    BC_DP:    edit_dp[0] <= 1'b1;
                    BC_CLEAR: begin
                        edit_buf <= '0;
                        edit_dp  <= '0;
                    end
                    BC_BLANK: blank_mode <= !blank_mode;
                    BC_COMMIT: begin
                        disp_value   <= edit_buf;
                        disp_dp      <= edit_dp;
                        commit_pulse <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A response arriving while the slot is full and stalled is dropped;
    // an accept in the same cycle frees the slot for it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (rsp_push && (!tx_valid || uart.tx_ready)) begin
            tx_valid <= 1'b1;
            tx_data  <= rsp_byte;
        end else if (tx_valid && uart.tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    assign uart.tx_valid = tx_valid;
    assign uart.tx_data  = tx_data;

    seg_scan #(
        .NUM_DIGITS     (NUM_DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW (DIG_ACTIVE_LOW)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_value (disp_value),
        .disp_dp    (disp_dp),
        .blank_mode (blank_mode),
        .seg_data   (seg_data),
        .scan_sig   (scan_sig)
    );

endmodule

// File: tb/tb_seg_uart_display.sv
// Scoreboard bench: stimulus pushes expected acks/commits, a monitor pops and compares;
// the scanned display is checked against a digit-level reference model.
module tb_seg_uart_display;

    localparam int ND = 3;
    localparam int SD = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [7:0]          seg_data;
    logic [ND-1:0]       scan_sig;
    logic [4*ND-1:0]     disp_value;
    logic                commit_pulse;

    seg_uart_display_if uart ();

    seg_uart_display #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .uart         (uart),
        .seg_data     (seg_data),
        .scan_sig     (scan_sig),
        .disp_value   (disp_value),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;

    logic [7:0]      rsp_q[$];
    logic [4*ND-1:0] commit_q[$];

    // Reference model state: values as plain integers
    int unsigned m_edit, m_disp, m_edp, m_ddp;
    bit          m_blank, m_slot_full;

    localparam logic [6:0] LUT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int i);
        int unsigned upper;
        logic [7:0]  raw;
        upper = m_disp >> (4 * i);
        raw   = (m_blank && i > 0 && upper == 0) ? 8'h00 : {1'b0, LUT[upper & 15]};
        if (m_ddp[i]) raw[7] = 1'b1;
        return ~raw;
    endfunction

    task automatic model_reset();
        m_edit = 0; m_disp = 0; m_edp = 0; m_ddp = 0;
        m_blank = 1'b0; m_slot_full = 1'b0;
        rsp_q.delete();
        commit_q.delete();
    endtask

    task automatic model(input logic [7:0] b);
        int resp;
        int nib;
        resp = -1;
        nib  = -1;
        if (b >= "0" && b <= "9")      nib = int'(b) - 48;
        else if (b >= "a" && b <= "f") nib = int'(b) - 97 + 10;
        else if (b >= "A" && b <= "F") nib = int'(b) - 65 + 10;
        if (nib >= 0) begin
            m_edit = (m_edit * 16 + nib) % (1 << (4 * ND));
            m_edp  = (m_edp * 2) % (1 << ND);
        end else if (b == 8'h2E) begin
            m_edp = m_edp | 1;
        end else if (b == 8'h23) begin
            m_edit = 0; m_edp = 0;
        end else if (b == 8'h7A) begin
            m_blank = !m_blank;
        end else if (b == 8'h0D) begin
            m_disp = m_edit; m_ddp = m_edp;
            commit_q.push_back(m_edit[4*ND-1:0]);
            resp = 'h4B;
        end else if (b != 8'h0A) begin
            resp = 'h3F;
        end
        if (resp >= 0 && !(uart.tx_ready == 1'b0 && m_slot_full)) begin
            rsp_q.push_back(resp[7:0]);
            if (uart.tx_ready == 1'b0) m_slot_full = 1'b1;
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        uart.rx_valid = 1'b1;
        uart.rx_data  = b;
        model(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            uart.rx_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i]);
        idle(2);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || commit_q.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain", rsp_q.size() + commit_q.size(), 0);
        idle(3);
    endtask

    task automatic check_display();
        logic [ND-1:0] sel;
        repeat (2 * ND * SD) begin
            @(negedge clk);
            sel = ~scan_sig;
            check("scan_onehot", $onehot(sel), 1);
            for (int i = 0; i < ND; i++)
                if (sel[i]) check($sformatf("seg_digit%0d", i), seg_data, exp_seg(i));
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a handshake or a commit
    logic [7:0]      mon_rsp;
    logic [4*ND-1:0] mon_val;
    always @(negedge clk) begin
        if (reset_n) begin
            if (uart.tx_valid && uart.tx_ready) begin
                hs_count++;
                check("tx_expected", rsp_q.size() != 0, 1);
                if (rsp_q.size() != 0) begin
                    mon_rsp = rsp_q.pop_front();
                    check("tx_data", uart.tx_data, mon_rsp);
                end
            end
            if (commit_pulse) begin
                check("commit_expected", commit_q.size() != 0, 1);
                if (commit_q.size() != 0) begin
                    mon_val = commit_q.pop_front();
                    check("disp_value", disp_value, mon_val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string          hexchars;
        logic [7:0]     cmds [0:5];
        logic [4*ND-1:0] prev;
        int             h0, dwell, r;
        logic [7:0]     b;

        hexchars = "0123456789abcdefABCDEF";
        cmds = '{8'h2E, 8'h23, 8'h7A, 8'h0D, 8'h0A, 8'h0D};
        uart.rx_valid = 1'b0;
        uart.rx_data  = 8'h00;
        uart.tx_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", uart.tx_valid, 0);
        check("rst_tx_data", uart.tx_data, 0);
        check("rst_disp", disp_value, 0);
        check("rst_commit", commit_pulse, 0);
        check("rst_seg", seg_data, 8'hFF);
        check("rst_scan", scan_sig, 3'b111);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic commit and scanned digits
        send_str("12A\r");
        drain();
        check("disp_12A", disp_value, 12'h12A);
        check_display();

        // Overflow discards the MSB nibble
        send_str("1234\r");
        drain();
        check("disp_234", disp_value, 12'h234);

        // Decimal point, then leading-zero blanking toggled without commit
        send_str("#5.\r");
        drain();
        check("disp_005", disp_value, 12'h005);
        check_display();
        send_str("z");
        drain();
        check_display();

        // Single-entry slot: second '?' dropped while stalled
        uart.tx_ready = 1'b0;
        drive("x"); idle(3);
        drive("#"); idle(2);
        drive("q"); idle(3);
        @(negedge clk);
        check("stall_tx_valid", uart.tx_valid, 1);
        check("stall_tx_data", uart.tx_data, 8'h3F);
        h0 = hs_count;
        @(posedge clk);
        #1;
        uart.tx_ready = 1'b1;
        m_slot_full   = 1'b0;
        idle(5);
        check("one_handshake", hs_count - h0, 1);
        check("slot_empty", uart.tx_valid, 0);

        // Back-to-back '7' and CR: display updates exactly at N+3
        prev = disp_value;
        drive("7");
        drive(8'h0D);
        idle(1);
        check("pre_commit", disp_value, prev);
        idle(1);
        check("commit_n3", disp_value, 12'h007);
        drain();

        // Randomised byte stream with gaps of 0..2 cycles
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      b = hexchars[$urandom_range(0, 21)];
            else if (r < 8) b = cmds[$urandom_range(0, 5)];
            else            b = 8'($urandom_range(0, 255));
            drive(b);
            idle($urandom_range(0, 2));
        end
        idle(2);
        drain();
        check("rand_disp", disp_value, m_disp[4*ND-1:0]);
        check_display();

        // Reset while CR is in the decode stage and a response is pending
        uart.tx_ready = 1'b0;
        send_str("3");
        drive("x"); idle(3);
        drive(8'h0D);
        @(posedge clk);
        #1;
        uart.rx_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_tx_valid", uart.tx_valid, 0);
        check("mid_rst_disp", disp_value, 0);
        check("mid_rst_seg", seg_data, 8'hFF);
        check("mid_rst_scan", scan_sig, 3'b111);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        uart.tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_scan", scan_sig, 3'b110);
        check("post_rst_seg", seg_data, 8'hC0);
        check("post_rst_disp", disp_value, 0);
        check("post_rst_tx_valid", uart.tx_valid, 0);
        dwell = 0;
        while (scan_sig == 3'b110 && dwell < 100) begin
            dwell++;
            @(negedge clk);
        end
        check("dwell_digit0", dwell, SD);
        dwell = 0;
        while (scan_sig == 3'b101 && dwell < 100) begin
            dwell++;
            @(negedge clk);
        end
        check("dwell_digit1", dwell, SD);
        idle(4);
        check("final_queues", rsp_q.size() + commit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
